// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command arbiter: command layout, op codes and FSM encoding.
package alsu_pkg;
    localparam int REP_W      = 3;
    localparam int ALSU_CMD_W = 16;
    localparam int CMD_W      = REP_W + ALSU_CMD_W;

    localparam int BYP_B_BIT = 0;
    localparam int BYP_A_BIT = 1;
    localparam int RED_B_BIT = 2;
    localparam int RED_A_BIT = 3;
    localparam int DIR_BIT   = 4;
    localparam int SIN_BIT   = 5;
    localparam int CIN_BIT   = 6;
    localparam int OP_LSB    = 7;
    localparam int B_LSB     = 10;
    localparam int A_LSB     = 13;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_XOR   = 3'b001,
        OP_ADD   = 3'b010,
        OP_MUL   = 3'b011,
        OP_SHIFT = 3'b100,
        OP_ROT   = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Only un-bypassed shift/rotate ops honour the repeat field.
    function automatic logic is_repeatable(input logic [ALSU_CMD_W-1:0] cmd);
        logic [2:0] op;
        op = cmd[OP_LSB +: 3];
        return (op == OP_SHIFT || op == OP_ROT) && !cmd[BYP_A_BIT] && !cmd[BYP_B_BIT];
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant/ready, registered last-grant pointer.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant,
    output logic ready0,
    output logic ready1
);
    logic last_grant;

    always_comb begin
        grant = valid1;
        if (valid0 && valid1) grant = ~last_grant;
    end

    // Ready is held low while reset is asserted even though the FSM sits in IDLE.
    assign ready0 = en & rst_n & ~grant;
    assign ready1 = en & rst_n & grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (en && (valid0 || valid1)) begin
            last_grant <= grant;
        end
    end
endmodule

// File: rtl/alsu_cmd_arbiter.sv
// Shares one ALSU between two requesters: arbitrates, issues (with shift/rotate repeats),
// captures the ALSU result and returns it on a valid/ready response port.
module alsu_cmd_arbiter
    import alsu_pkg::*;
#(
    parameter int REP_W = 3
) (
    input  logic                        clock_100Mhz,
    input  logic                        rst_n,
    input  logic                        req0_valid,
    input  logic [REP_W+ALSU_CMD_W-1:0] req0_cmd,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [REP_W+ALSU_CMD_W-1:0] req1_cmd,
    output logic                        req1_ready,
    output logic [ALSU_CMD_W-1:0]       alsu_cmd,
    output logic                        alsu_ce,
    input  logic [5:0]                  alsu_out,
    input  logic                        alsu_valid,
    output logic                        rsp_valid,
    output logic                        rsp_id,
    output logic [5:0]                  rsp_data,
    output logic                        rsp_err,
    input  logic                        rsp_ready
);
    localparam int FULL_W = REP_W + ALSU_CMD_W;

    state_e              state;
    logic [REP_W-1:0]    rep_cnt;
    logic                grant;
    logic                accept;
    logic [FULL_W-1:0]   sel_cmd;

    rr_arbiter2 u_arb (
        .clk    (clock_100Mhz),
        .rst_n  (rst_n),
        .en     (state == ST_IDLE),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant  (grant),
        .ready0 (req0_ready),
        .ready1 (req1_ready)
    );

    assign accept  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel_cmd = grant ? req1_cmd : req0_cmd;

    always_ff @(posedge clock_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alsu_cmd  <= '0;
            alsu_ce   <= 1'b0;
            rep_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alsu_cmd <= sel_cmd[ALSU_CMD_W-1:0];
                        rsp_id   <= grant;
                        rep_cnt  <= is_repeatable(sel_cmd[ALSU_CMD_W-1:0]) ?
                                    sel_cmd[FULL_W-1 -: REP_W] : '0;
                        alsu_ce  <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // One ALSU clock-enable per remaining repeat, plus the initial one.
                    if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - 1'b1;
                    end else begin
                        alsu_ce <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    rsp_data  <= alsu_out;
                    rsp_err   <= ~alsu_valid;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alsu_cmd_arbiter.sv
// Bench for alsu_cmd_arbiter: behavioural ALSU, directed vector table, corner sequences, random run.
module tb_alsu_cmd_arbiter;
    import alsu_pkg::*;

    localparam logic [6:0] F_CIN = 7'h40;
    localparam logic [6:0] F_SIN = 7'h20;
    localparam logic [6:0] F_DIR = 7'h10;
    localparam logic [6:0] F_RA  = 7'h08;
    localparam logic [6:0] F_RB  = 7'h04;
    localparam logic [6:0] F_BA  = 7'h02;
    localparam logic [6:0] F_BB  = 7'h01;

    logic             clock_100Mhz = 1'b0;
    logic             rst_n = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req1_valid = 1'b0;
    logic [CMD_W-1:0] req0_cmd = '0;
    logic [CMD_W-1:0] req1_cmd = '0;
    logic             req0_ready, req1_ready;
    logic [15:0]      alsu_cmd;
    logic             alsu_ce;
    logic [5:0]       alsu_out;
    logic             alsu_valid;
    logic             rsp_valid, rsp_id, rsp_err;
    logic [5:0]       rsp_data;
    logic             rsp_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    alsu_cmd_arbiter #(.REP_W(REP_W)) dut (
        .clock_100Mhz (clock_100Mhz),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_cmd     (req0_cmd),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_cmd     (req1_cmd),
        .req1_ready   (req1_ready),
        .alsu_cmd     (alsu_cmd),
        .alsu_ce      (alsu_ce),
        .alsu_out     (alsu_out),
        .alsu_valid   (alsu_valid),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    // One ALSU evaluation: returns {valid, out}.
    function automatic logic [6:0] alsu_step(input logic [15:0] c, input logic [5:0] prev);
        logic [5:0] a, b, r;
        logic [2:0] op;
        a  = {3'b0, c[A_LSB +: 3]};
        b  = {3'b0, c[B_LSB +: 3]};
        op = c[OP_LSB +: 3];
        if (op == 3'b110 || op == 3'b111 ||
            ((c[RED_A_BIT] || c[RED_B_BIT]) && op != OP_AND && op != OP_XOR))
            return 7'd0;
        if (c[BYP_A_BIT]) r = a;
        else if (c[BYP_B_BIT]) r = b;
        else begin
            case (op)
                OP_AND:  r = c[RED_A_BIT] ? {5'b0, &a[2:0]} : c[RED_B_BIT] ? {5'b0, &b[2:0]} : (a & b);
                OP_XOR:  r = c[RED_A_BIT] ? {5'b0, ^a[2:0]} : c[RED_B_BIT] ? {5'b0, ^b[2:0]} : (a ^ b);
                OP_ADD:  r = a + b + {5'b0, c[CIN_BIT]};
                OP_MUL:  r = a * b;
                OP_SHIFT: r = c[DIR_BIT] ? {prev[4:0], c[SIN_BIT]} : {c[SIN_BIT], prev[5:1]};
                default: r = c[DIR_BIT] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            endcase
        end
        return {1'b1, r};
    endfunction

    // Environment ALSU: output register updates only while enabled.
    always @(posedge clock_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            alsu_out   <= '0;
            alsu_valid <= 1'b1;
        end else if (alsu_ce) begin
            {alsu_valid, alsu_out} <= alsu_step(alsu_cmd, alsu_out);
        end
    end

    function automatic logic [CMD_W-1:0] mk(input logic [31:0] rep, input logic [31:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [6:0] fl);
        return {rep[2:0], a[2:0], b[2:0], op[2:0], fl};
    endfunction

    function automatic logic [CMD_W-1:0] rand_cmd();
        logic [6:0] fl;
        fl = 7'($urandom_range(0, 127)) & (F_CIN | F_SIN | F_DIR);
        if ($urandom_range(0, 7) == 0) fl = fl | F_RA;
        if ($urandom_range(0, 7) == 0) fl = fl | F_RB;
        if ($urandom_range(0, 7) == 0) fl = fl | F_BA;
        if ($urandom_range(0, 7) == 0) fl = fl | F_BB;
        return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), fl);
    endfunction

    // Number of ALSU enables a command should receive.
    function automatic int issue_count(input logic [CMD_W-1:0] c);
        int op;
        op = int'(c[OP_LSB +: 3]);
        if ((op == 4 || op == 5) && !c[BYP_A_BIT] && !c[BYP_B_BIT]) return int'(c[CMD_W-1 -: 3]) + 1;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic accept_any(output int p);
        p = -1;
        for (int i = 0; i < 20 && p < 0; i++) begin
            #1;
            if (req0_valid && req0_ready) p = 0;
            else if (req1_valid && req1_ready) p = 1;
            @(posedge clock_100Mhz);
            @(negedge clock_100Mhz);
        end
    endtask

    task automatic wait_rsp(output int lat, output int ce_cnt);
        lat = 0;
        ce_cnt = 0;
        while (!rsp_valid && lat < 40) begin
            if (alsu_ce) ce_cnt++;
            @(negedge clock_100Mhz);
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clock_100Mhz);
        @(negedge clock_100Mhz);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic             port;
        logic [CMD_W-1:0] cmd;
        logic [5:0]       data;
        logic             err;
        int               n;
    } vec_t;

    vec_t vt[13];

    int         p, lat, ce_cnt;
    bit         stall_ok;
    logic       pend0, pend1, g;
    int         m_mode, m_t, m_n;
    logic       m_last, m_id, m_err;
    logic [5:0] m_data, ref_alsu;
    logic [CMD_W-1:0] m_cmd;
    logic [6:0] step;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, mk(0, OP_AND, 5, 3, 7'h0),        6'd1,  1'b0, 1};
        vt[1]  = '{1'b0, mk(0, OP_AND, 1, 0, F_BA),        6'd1,  1'b0, 1};
        vt[2]  = '{1'b0, mk(2, OP_SHIFT, 0, 0, F_DIR),     6'd8,  1'b0, 3};
        vt[3]  = '{1'b0, mk(0, OP_ADD, 3, 2, F_RA),        6'd0,  1'b1, 1};
        vt[4]  = '{1'b0, mk(5, OP_MUL, 2, 3, 7'h0),        6'd6,  1'b0, 1};
        vt[5]  = '{1'b1, mk(1, OP_ROT, 0, 0, 7'h0),        6'd33, 1'b0, 2};
        vt[6]  = '{1'b1, mk(0, OP_XOR, 5, 6, 7'h0),        6'd3,  1'b0, 1};
        vt[7]  = '{1'b0, mk(3, OP_SHIFT, 0, 7, F_BB),      6'd7,  1'b0, 1};
        vt[8]  = '{1'b0, mk(0, OP_ADD, 7, 7, F_CIN),       6'd15, 1'b0, 1};
        vt[9]  = '{1'b1, mk(7, OP_SHIFT, 0, 0, F_SIN),     6'd63, 1'b0, 8};
        vt[10] = '{1'b0, mk(0, 3'b110, 1, 1, 7'h0),        6'd0,  1'b1, 1};
        vt[11] = '{1'b0, mk(0, OP_AND, 5, 0, F_BA),        6'd5,  1'b0, 1};
        vt[12] = '{1'b1, mk(3, OP_ROT, 0, 0, F_DIR),       6'd17, 1'b0, 4};

        // Reset with both requesters asking.
        #1 rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clock_100Mhz);
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_ce", alsu_ce, 0);
        check("rst_rsp_valid", rsp_valid, 0);

        // Start a long shift on req1, then reset in the middle of ISSUE.
        req0_valid = 1'b0;
        req1_cmd   = mk(4, OP_SHIFT, 0, 0, F_DIR | F_SIN);
        @(negedge clock_100Mhz);
        rst_n = 1'b1;
        accept_any(p);
        check("pre_rst_grant", p, 1);
        @(negedge clock_100Mhz);
        check("pre_rst_issue", alsu_ce, 1);
        req0_cmd   = mk(0, OP_MUL, 2, 3, 7'h0);
        req1_cmd   = mk(0, OP_XOR, 5, 6, 7'h0);
        req0_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_alsu_cmd", alsu_cmd, 0);
        check("midrst_ce", alsu_ce, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_id", rsp_id, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_rsp_err", rsp_err, 0);
        check("midrst_ready0", req0_ready, 0);
        check("midrst_ready1", req1_ready, 0);
        @(negedge clock_100Mhz);
        rst_n = 1'b1;

        // Both requesters held valid: grants must alternate starting with req0.
        for (int k = 0; k < 4; k++) begin
            accept_any(p);
            check($sformatf("alt%0d_grant", k), p, k % 2);
            wait_rsp(lat, ce_cnt);
            check($sformatf("alt%0d_lat", k), lat, 2);
            check($sformatf("alt%0d_id", k), rsp_id, k % 2);
            check($sformatf("alt%0d_data", k), rsp_data, (k % 2) ? 3 : 6);
            check($sformatf("alt%0d_err", k), rsp_err, 0);
            handshake();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Directed vector table, applied in order (ALSU state carries across rows).
        for (int i = 0; i < 13; i++) begin
            if (vt[i].port) begin
                req1_cmd = vt[i].cmd;
                req1_valid = 1'b1;
            end else begin
                req0_cmd = vt[i].cmd;
                req0_valid = 1'b1;
            end
            accept_any(p);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check($sformatf("vec%0d_grant", i), p, vt[i].port);
            wait_rsp(lat, ce_cnt);
            check($sformatf("vec%0d_lat", i), lat, vt[i].n + 1);
            check($sformatf("vec%0d_ce_cycles", i), ce_cnt, vt[i].n);
            check($sformatf("vec%0d_id", i), rsp_id, vt[i].port);
            check($sformatf("vec%0d_data", i), rsp_data, vt[i].data);
            check($sformatf("vec%0d_err", i), rsp_err, vt[i].err);
            handshake();
        end

        // Response back-pressure for 10 cycles with both requesters waiting.
        req0_cmd = mk(0, OP_AND, 7, 7, 7'h0);
        req0_valid = 1'b1;
        accept_any(p);
        check("stall_grant", p, 0);
        req1_cmd = mk(0, OP_XOR, 5, 6, 7'h0);
        req1_valid = 1'b1;
        wait_rsp(lat, ce_cnt);
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!(rsp_valid && rsp_data == 6'd7 && rsp_id == 1'b0 && !rsp_err &&
                  !req0_ready && !req1_ready)) stall_ok = 1'b0;
            @(negedge clock_100Mhz);
        end
        check("stall_hold", stall_ok, 1);
        handshake();
        #1;
        check("stall_release_valid", rsp_valid, 0);
        check("stall_release_ready1", req1_ready, 1);
        @(posedge clock_100Mhz);
        @(negedge clock_100Mhz);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("stall_next_ce", alsu_ce, 1);
        check("stall_next_cmd", alsu_cmd, req1_cmd[15:0]);
        wait_rsp(lat, ce_cnt);
        check("stall_next_data", rsp_data, 3);
        check("stall_next_id", rsp_id, 1);
        handshake();

        // Randomized traffic against a transaction-level model.
        rst_n = 1'b0;
        @(negedge clock_100Mhz);
        rst_n = 1'b1;
        pend0 = 1'b0;
        pend1 = 1'b0;
        m_mode = 0;
        m_t = 0;
        m_n = 1;
        m_last = 1'b1;
        ref_alsu = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clock_100Mhz);
            if (m_mode == 2) begin
                check("rnd_rsp_valid", rsp_valid, 1);
                check("rnd_rsp_id", rsp_id, m_id);
                check("rnd_rsp_data", rsp_data, m_data);
                check("rnd_rsp_err", rsp_err, m_err);
            end else begin
                check("rnd_rsp_valid", rsp_valid, 0);
                check("rnd_ce", alsu_ce, (m_mode == 1 && m_t < m_n) ? 1 : 0);
                if (m_mode == 1) check("rnd_alsu_cmd", alsu_cmd, m_cmd[15:0]);
            end
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1'b1;
                req0_cmd = rand_cmd();
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1'b1;
                req1_cmd = rand_cmd();
            end
            req0_valid = pend0;
            req1_valid = pend1;
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            g = (pend0 && pend1) ? ~m_last : pend1;
            check("rnd_acc0", req0_valid & req0_ready, (m_mode == 0 && pend0 && !g) ? 1 : 0);
            check("rnd_acc1", req1_valid & req1_ready, (m_mode == 0 && pend1 && g) ? 1 : 0);
            case (m_mode)
                0: if (pend0 || pend1) begin
                    m_cmd  = g ? req1_cmd : req0_cmd;
                    m_id   = g;
                    m_last = g;
                    if (g) pend1 = 1'b0;
                    else pend0 = 1'b0;
                    m_n = issue_count(m_cmd);
                    for (int r = 0; r < m_n; r++) begin
                        step = alsu_step(m_cmd[15:0], ref_alsu);
                        ref_alsu = step[5:0];
                    end
                    m_data = ref_alsu;
                    m_err  = ~step[6];
                    m_t    = 0;
                    m_mode = 1;
                end
                1: begin
                    m_t++;
                    if (m_t == m_n + 1) m_mode = 2;
                end
                default: if (rsp_ready) m_mode = 0;
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
